// File: rtl/dct8_stream_engine.sv
// Streaming 8-point 1-D DCT-II / IDCT engine.
// Samples enter serially; eight MAC lanes accumulate one block while the
// previous block drains from an output buffer, one coefficient per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     sample handshake, in_data signed sample
//   in_inv                block mode (0 forward, 1 inverse), taken on sample 0
//   out_valid/out_ready   result handshake
//   out_data              signed, rounded and saturated result
//   out_idx, out_last     result index 0..7, high on index 7
//   out_sat               result was clamped
module dct8_stream_engine #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned COE_WIDTH  = 12,
    parameter int unsigned OUT_WIDTH  = 13
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_inv,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic [2:0]                   out_idx,
    output logic                         out_last,
    output logic                         out_sat
);
    localparam int unsigned COE_FRAC   = COE_WIDTH - 1;
    localparam int unsigned ACC_WIDTH  = DATA_WIDTH + COE_WIDTH + 3;
    localparam int unsigned PROD_WIDTH = DATA_WIDTH + COE_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO = ACC_WIDTH'(0);
    localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) <<< (COE_FRAC - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX  = (ACC_WIDTH'(1) <<< (OUT_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN  = ~OUT_MAX;

    typedef enum logic {ST_ACC, ST_HOLD} acc_state_t;
    typedef enum logic {ST_EMPTY, ST_DRAIN} out_state_t;

    // DCT-II basis value, rounded to nearest, evaluated at elaboration only
    function automatic logic signed [COE_WIDTH-1:0] coe_calc(input int k, input int n);
        real s;
        real v;
        int  r;
        s = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
        v = s * $cos(real'((2 * n + 1) * k) * 3.14159265358979323846 / 16.0) * (2.0 ** real'(COE_FRAC));
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return COE_WIDTH'(r);
    endfunction

    logic signed [COE_WIDTH-1:0] coef_tab [8][8];

    for (genvar gk = 0; gk < 8; gk++) begin : g_row
        for (genvar gn = 0; gn < 8; gn++) begin : g_col
            localparam logic signed [COE_WIDTH-1:0] CV = coe_calc(gk, gn);
            assign coef_tab[gk][gn] = CV;
        end
    end

    acc_state_t acc_state_q, acc_state_d;
    out_state_t out_state_q, out_state_d;

    logic [2:0]                   cnt_q;
    logic                         inv_q;
    logic signed [ACC_WIDTH-1:0]  acc_q    [8];
    logic signed [OUT_WIDTH-1:0]  obuf_data [8];
    logic [7:0]                   obuf_sat;

    logic                         in_fire, out_fire, last_beat, buf_free, xfer, blk_inv;
    logic [2:0]                   idx_inc;
    logic signed [COE_WIDTH-1:0]  lane_coe  [8];
    logic signed [PROD_WIDTH-1:0] lane_prod [8];
    logic signed [ACC_WIDTH-1:0]  acc_upd   [8];
    logic signed [ACC_WIDTH-1:0]  acc_src   [8];
    logic signed [ACC_WIDTH-1:0]  acc_rnd   [8];
    logic signed [OUT_WIDTH-1:0]  lane_out  [8];
    logic [7:0]                   lane_sat;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_beat = in_fire & (cnt_q == 3'd7);
    // Buffer can take a block if empty or its final beat leaves this cycle
    assign buf_free  = (out_state_q == ST_EMPTY) | (out_fire & (out_idx == 3'd7));
    assign xfer      = ((acc_state_q == ST_HOLD) | last_beat) & buf_free;
    // Mode comes straight from the port on sample 0, from the latch afterwards
    assign blk_inv   = (cnt_q == 3'd0) ? in_inv : inv_q;
    assign idx_inc   = out_idx + 3'd1;

    // MAC lanes plus round/saturate of whatever block is being transferred
    always_comb begin
        lane_sat = '0;
        for (int j = 0; j < 8; j++) begin
            lane_coe[j]  = blk_inv ? coef_tab[cnt_q][j] : coef_tab[j][cnt_q];
            lane_prod[j] = PROD_WIDTH'(in_data) * PROD_WIDTH'(lane_coe[j]);
            acc_upd[j]   = ((cnt_q == 3'd0) ? ACC_ZERO : acc_q[j]) + ACC_WIDTH'(lane_prod[j]);
            acc_src[j]   = (acc_state_q == ST_HOLD) ? acc_q[j] : acc_upd[j];
            acc_rnd[j]   = (acc_src[j] + RND_HALF) >>> COE_FRAC;
            lane_out[j]  = OUT_WIDTH'(acc_rnd[j]);
            if (acc_rnd[j] > OUT_MAX) begin
                lane_out[j] = OUT_WIDTH'(OUT_MAX);
                lane_sat[j] = 1'b1;
            end else if (acc_rnd[j] < OUT_MIN) begin
                lane_out[j] = OUT_WIDTH'(OUT_MIN);
                lane_sat[j] = 1'b1;
            end
        end
    end

    // Accumulator side next state
    always_comb begin
        acc_state_d = acc_state_q;
        case (acc_state_q)
            ST_ACC:  if (last_beat && !xfer) acc_state_d = ST_HOLD;
            ST_HOLD: if (xfer) acc_state_d = ST_ACC;
            default: acc_state_d = ST_ACC;
        endcase
    end

    // Output side next state
    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            ST_EMPTY: if (xfer) out_state_d = ST_DRAIN;
            ST_DRAIN: if (out_fire && (out_idx == 3'd7) && !xfer) out_state_d = ST_EMPTY;
            default:  out_state_d = ST_EMPTY;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_state_q <= ST_ACC;
            out_state_q <= ST_EMPTY;
        end else begin
            acc_state_q <= acc_state_d;
            out_state_q <= out_state_d;
        end
    end

    // Accumulators, sample counter and latched mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 8; j++) acc_q[j] <= '0;
            cnt_q <= '0;
            inv_q <= 1'b0;
        end else if (in_fire) begin
            for (int j = 0; j < 8; j++) acc_q[j] <= acc_upd[j];
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd0) inv_q <= in_inv;
        end
    end

    // Output buffer and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 8; j++) obuf_data[j] <= '0;
            obuf_sat  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            in_ready  <= (acc_state_d == ST_ACC);
            out_valid <= (out_state_d == ST_DRAIN);
            if (xfer) begin
                for (int j = 0; j < 8; j++) obuf_data[j] <= lane_out[j];
                obuf_sat <= lane_sat;
                out_data <= lane_out[0];
                out_sat  <= lane_sat[0];
                out_idx  <= '0;
                out_last <= 1'b0;
            end else if (out_fire) begin
                if (out_idx == 3'd7) begin
                    out_data <= '0;
                    out_sat  <= 1'b0;
                    out_idx  <= '0;
                    out_last <= 1'b0;
                end else begin
                    out_data <= obuf_data[idx_inc];
                    out_sat  <= obuf_sat[idx_inc];
                    out_idx  <= idx_inc;
                    out_last <= (idx_inc == 3'd7);
                end
            end
        end
    end

endmodule
